// File: rtl/macro_fifo_d4_pkg.sv
// Shared sizing constants for the 4-entry macro FIFO and its pointer ROM.
package macro_fifo_d4_pkg;

    localparam int FIFO_D4_DEPTH = 4;
    localparam int FIFO_D4_PTR_W = 3;
    localparam int FIFO_D4_IDX_W = 2;

endpackage

// File: rtl/macro_rom_incr2.sv
// 2-bit increment ROM: q = addr + 1 modulo 4, carry flags the 3 -> 0 wrap.
module macro_rom_incr2
    import macro_fifo_d4_pkg::*;
(
    input  logic [FIFO_D4_IDX_W-1:0] addr,
    output logic [FIFO_D4_IDX_W-1:0] q,
    output logic                     carry
);

    always_comb begin
        q     = '0;
        carry = 1'b0;
        case (addr)
            2'd0: q = 2'd1;
            2'd1: q = 2'd2;
            2'd2: q = 2'd3;
            2'd3: begin
                q     = 2'd0;
                carry = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/macro_fifo_d4.sv
// 4-entry valid/ready FIFO with wrap-bit pointers advanced by increment ROMs.
// Optional same-cycle pass-through when empty: define MACRO_FIFO_D4_BYPASS_EN.
module macro_fifo_d4
    import macro_fifo_d4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [2:0]       level,
    output logic             full,
    output logic             empty
);

    logic [FIFO_D4_PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0]         mem_q [FIFO_D4_DEPTH];
    logic [WIDTH-1:0]         mem_d [FIFO_D4_DEPTH];

    logic [FIFO_D4_IDX_W-1:0] widx_next, ridx_next;
    logic                     wcarry, rcarry;
    logic                     push, pop, bypass;

    macro_rom_incr2 u_wrom (
        .addr  (wptr_q[FIFO_D4_IDX_W-1:0]),
        .q     (widx_next),
        .carry (wcarry)
    );

    macro_rom_incr2 u_rrom (
        .addr  (rptr_q[FIFO_D4_IDX_W-1:0]),
        .q     (ridx_next),
        .carry (rcarry)
    );

    assign level   = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[1:0] == rptr_q[1:0]) && (wptr_q[2] != rptr_q[2]);
    assign s_ready = !full;

`ifdef MACRO_FIFO_D4_BYPASS_EN
    // An empty FIFO hands the incoming beat straight to the consumer without storing it.
    assign bypass  = empty && s_valid && m_ready && !flush;
    assign m_valid = !empty || bypass;
    assign m_data  = empty ? s_data : mem_q[rptr_q[FIFO_D4_IDX_W-1:0]];
`else
    assign bypass  = 1'b0;
    assign m_valid = !empty;
    assign m_data  = mem_q[rptr_q[FIFO_D4_IDX_W-1:0]];
`endif

    assign push = s_valid && s_ready && !bypass;
    assign pop  = !empty && m_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q[FIFO_D4_IDX_W-1:0]] = s_data;
                wptr_d = {wptr_q[2] ^ wcarry, widx_next};
            end
            if (pop) begin
                rptr_d = {rptr_q[2] ^ rcarry, ridx_next};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; m_data is only meaningful with m_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_macro_fifo_d4.sv
// Directed self-checking bench for macro_fifo_d4 (both bypass build options).
module tb_macro_fifo_d4;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] level;
    logic       full;
    logic       empty;

    int checkCount;
    int errorCount;

    macro_fifo_d4 #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            checkOutput("idle_level", level, 0);
            checkOutput("idle_empty", empty, 1);
            checkOutput("idle_s_ready", s_ready, 1);
            checkOutput("idle_m_valid", m_valid, 0);
            applyStimulus();
        end

        // Fill to four entries with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h11 * (i + 1));
            checkOutput("fill_s_ready", s_ready, 1);
            applyStimulus();
            checkOutput("fill_level", level, i + 1);
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_s_ready_low", s_ready, 0);
        s_data = 8'h55;
        applyStimulus();
        checkOutput("fifth_level", level, 4);
        checkOutput("fifth_head", m_data, 8'h11);
        s_valid = 1'b0;

        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_m_valid", m_valid, 1);
            checkOutput("drain_m_data", m_data, 8'(8'h11 * (i + 1)));
            applyStimulus();
        end
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_level", level, 0);

        // Streaming: every beat should come out one cycle later, wrapping pointers twice.
        s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_data = 8'(k);
`ifdef MACRO_FIFO_D4_BYPASS_EN
            checkOutput("stream_m_valid", m_valid, 1);
            checkOutput("stream_m_data", m_data, k);
            applyStimulus();
            checkOutput("stream_level", level, 0);
`else
            if (k == 0) begin
                checkOutput("stream_first_m_valid", m_valid, 0);
            end else begin
                checkOutput("stream_m_valid", m_valid, 1);
                checkOutput("stream_m_data", m_data, k - 1);
            end
            applyStimulus();
            checkOutput("stream_level", level, 1);
`endif
        end
        s_valid = 1'b0;
`ifndef MACRO_FIFO_D4_BYPASS_EN
        checkOutput("stream_last_data", m_data, 8'h09);
        applyStimulus();
`endif
        checkOutput("stream_empty", empty, 1);
        m_ready = 1'b0;

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hA0 + i);
            applyStimulus();
        end
        checkOutput("full2_level", level, 4);
        s_data  = 8'hB0;
        m_ready = 1'b1;
        checkOutput("full2_s_ready", s_ready, 0);
        checkOutput("full2_head", m_data, 8'hA0);
        applyStimulus();
        s_valid = 1'b0;
        m_ready = 1'b0;
        checkOutput("full2_level_after", level, 3);
        checkOutput("full2_s_ready_after", s_ready, 1);
        checkOutput("full2_next_head", m_data, 8'hA1);

        // Reset mid-operation discards stored entries.
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("midreset_level", level, 0);
        checkOutput("midreset_m_valid", m_valid, 0);

        // Flush at level 2 with a concurrent push.
        s_valid = 1'b1;
        s_data  = 8'hC1;
        applyStimulus();
        s_data  = 8'hC2;
        applyStimulus();
        checkOutput("preflush_level", level, 2);
        flush  = 1'b1;
        s_data = 8'hAA;
        checkOutput("flush_s_ready", s_ready, 1);
        checkOutput("flush_m_valid", m_valid, 1);
        applyStimulus();
        flush   = 1'b0;
        s_valid = 1'b0;
        checkOutput("flush_level", level, 0);
        checkOutput("flush_empty", empty, 1);
        s_valid = 1'b1;
        s_data  = 8'h77;
        applyStimulus();
        s_valid = 1'b0;
        checkOutput("postflush_level", level, 1);
        checkOutput("postflush_data", m_data, 8'h77);
        m_ready = 1'b1;
        applyStimulus();
        checkOutput("postflush_empty", empty, 1);

`ifdef MACRO_FIFO_D4_BYPASS_EN
        // Same-cycle pass-through while empty.
        s_valid = 1'b1;
        s_data  = 8'h5A;
        #1;
        checkOutput("bypass_m_valid", m_valid, 1);
        checkOutput("bypass_m_data", m_data, 8'h5A);
        applyStimulus();
        s_valid = 1'b0;
        checkOutput("bypass_level", level, 0);
`endif
        m_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
